// File: rtl/traffic_sink_pkg.sv
// traffic_sink_pkg: shared widths, reset defaults, VC framing states,
// error-cause bit positions and small helpers for the traffic sink.
// Optional feature macro: SINK_LATENCY_EN (latency widths live here).
package traffic_sink_pkg;

   localparam int ROUTER_BITS      = 4;
   localparam int MAX_VC           = 4;
   localparam int VC_BITS          = 2;
   localparam int MAX_CREDIT_DELAY = 8;
   localparam int CNT_BITS         = 16;
   localparam int TS_BITS          = 16;
   localparam int DELAY_BITS       = 4;

   // Configuration values loaded by rst
   localparam logic [ROUTER_BITS-1:0] SINK_DEFAULT_NODE    = '0;
   localparam logic [VC_BITS:0]       SINK_DEFAULT_NUM_VCS = (VC_BITS+1)'(MAX_VC);
   localparam logic [DELAY_BITS-1:0]  SINK_DEFAULT_DELAY   = 4'd1;

   // Largest credit delay the pipe can realise
   localparam logic [DELAY_BITS-1:0]  CREDIT_DELAY_CLAMP   = DELAY_BITS'(MAX_CREDIT_DELAY);

   // Per-VC framing state
   typedef enum logic {
      VC_IDLE = 1'b0,
      VC_OPEN = 1'b1
   } vc_state_t;

   // Error cause bit positions; any set bit on a flit is one error
   localparam int ERR_BIT_FRAMING  = 0;
   localparam int ERR_BIT_DST      = 1;
   localparam int ERR_BIT_VC_RANGE = 2;
   localparam int ERR_CAUSES       = 3;

   // A delay of 0 behaves as 1; anything past the pipe depth is clamped
   function automatic logic [DELAY_BITS-1:0] clamp_delay(input logic [DELAY_BITS-1:0] d);
      if (d == '0)
         return 4'd1;
      else if (d > CREDIT_DELAY_CLAMP)
         return CREDIT_DELAY_CLAMP;
      else
         return d;
   endfunction

   // Saturating increment for statistics counters
   function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/traffic_sink_if.sv
// traffic_sink_if: ejection-port flit bus plus the returning credit.
// Optional feature macro: SINK_LATENCY_EN adds the flit timestamp.
//
// Handshake: valid-only, no ready. The router (master) drives flit_valid
// with its qualifiers for exactly one cycle per flit and the sink always
// accepts. The sink (slave) drives cr_valid/cr_vc for one cycle per
// returned credit; the router must take it in that cycle.
interface traffic_sink_if;
   import traffic_sink_pkg::*;

   logic                   flit_valid;
   logic [VC_BITS-1:0]     flit_vc;
   logic                   flit_head;
   logic                   flit_tail;
   logic [ROUTER_BITS-1:0] flit_dst;
`ifdef SINK_LATENCY_EN
   logic [TS_BITS-1:0]     flit_ts;
`endif
   logic                   cr_valid;
   logic [VC_BITS-1:0]     cr_vc;

   modport master (
      output flit_valid, flit_vc, flit_head, flit_tail, flit_dst,
`ifdef SINK_LATENCY_EN
      output flit_ts,
`endif
      input  cr_valid, cr_vc
   );

   modport slave (
      input  flit_valid, flit_vc, flit_head, flit_tail, flit_dst,
`ifdef SINK_LATENCY_EN
      input  flit_ts,
`endif
      output cr_valid, cr_vc
   );

endinterface

// File: rtl/traffic_sink_credit_delay_line.sv
// traffic_sink_credit_delay_line: shift pipe carrying (valid, vc) with a
// programmable tap. An entry pushed at edge t appears on the outputs in
// the cycle after edge t+tap-1. tap must be in 1..DEPTH.
module traffic_sink_credit_delay_line
   import traffic_sink_pkg::*;
#(
   parameter int DEPTH = MAX_CREDIT_DELAY,
   parameter int W     = VC_BITS
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [DELAY_BITS-1:0] tap,
   input  logic                  in_valid,
   input  logic [W-1:0]          in_vc,
   output logic                  out_valid,
   output logic [W-1:0]          out_vc
);

   localparam int IDX_BITS = $clog2(DEPTH);

   logic [DEPTH-1:0]    v_q;
   logic [W-1:0]        vc_q [DEPTH];
   logic [DELAY_BITS-1:0] idx;

   // Shift all stages every cycle; clr empties the pipe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v_q <= '0;
         for (int k = 0; k < DEPTH; k++) vc_q[k] <= '0;
      end else if (clr) begin
         v_q <= '0;
         for (int k = 0; k < DEPTH; k++) vc_q[k] <= '0;
      end else begin
         v_q     <= {v_q[DEPTH-2:0], in_valid};
         vc_q[0] <= in_vc;
         for (int k = 1; k < DEPTH; k++) vc_q[k] <= vc_q[k-1];
      end
   end

   // Tap the stage selected by the delay; vc reads 0 when nothing is due
   always_comb begin
      idx       = tap - 4'd1;
      out_valid = v_q[idx[IDX_BITS-1:0]];
      out_vc    = out_valid ? vc_q[idx[IDX_BITS-1:0]] : '0;
   end

endmodule

// File: rtl/traffic_sink.sv
// traffic_sink: ejection endpoint of one router. Accepts every flit, tracks
// per-VC packet framing, checks destination and VC range, returns credits
// after the configured delay and keeps saturating statistics.
// Optional feature macro: SINK_LATENCY_EN (packet latency sum/max).
module traffic_sink
   import traffic_sink_pkg::*;
(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_load,
   input  logic [ROUTER_BITS-1:0]       cfg_node_id,
   input  logic [VC_BITS:0]             cfg_num_vcs,
   input  logic [DELAY_BITS-1:0]        cfg_credit_delay,
`ifdef SINK_LATENCY_EN
   input  logic [TS_BITS-1:0]           cur_cycle,
   output logic [CNT_BITS+TS_BITS-1:0]  lat_sum,
   output logic [TS_BITS-1:0]           lat_max,
`endif
   traffic_sink_if.slave                flit_if,
   output logic [CNT_BITS-1:0]          flit_count,
   output logic [CNT_BITS-1:0]          pkt_count,
   output logic [CNT_BITS-1:0]          err_count,
   output logic                         err_flag,
   output logic [MAX_VC-1:0]            vc_busy
);

   logic [ROUTER_BITS-1:0] node_id_q;
   logic [VC_BITS:0]       num_vcs_q;
   logic [DELAY_BITS-1:0]  delay_q;
   vc_state_t              state_q [MAX_VC];

   logic                   accept;
   logic                   vc_in_range;
   vc_state_t              cur_state;
   vc_state_t              next_state;
   logic                   pkt_done;
   logic [ERR_CAUSES-1:0]  err_cause;

   // Classify the incoming flit against its VC's framing state
   always_comb begin
      accept      = flit_if.flit_valid & ~cfg_load;
      vc_in_range = {1'b0, flit_if.flit_vc} < num_vcs_q;
      cur_state   = state_q[flit_if.flit_vc];

      err_cause                   = '0;
      err_cause[ERR_BIT_VC_RANGE] = ~vc_in_range;
      err_cause[ERR_BIT_DST]      = flit_if.flit_head && (flit_if.flit_dst != node_id_q);
      err_cause[ERR_BIT_FRAMING]  = vc_in_range &&
                                    ((cur_state == VC_OPEN) ? flit_if.flit_head : ~flit_if.flit_head);

      // A head always restarts framing; a tail always closes it
      if (flit_if.flit_head)
         next_state = flit_if.flit_tail ? VC_IDLE : VC_OPEN;
      else if (flit_if.flit_tail)
         next_state = VC_IDLE;
      else
         next_state = cur_state;

      pkt_done = vc_in_range && flit_if.flit_tail &&
                 (flit_if.flit_head || (cur_state == VC_OPEN));
   end

   // Configuration registers with delay clamping on load
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         node_id_q <= SINK_DEFAULT_NODE;
         num_vcs_q <= SINK_DEFAULT_NUM_VCS;
         delay_q   <= SINK_DEFAULT_DELAY;
      end else if (cfg_load) begin
         node_id_q <= cfg_node_id;
         num_vcs_q <= cfg_num_vcs;
         delay_q   <= clamp_delay(cfg_credit_delay);
      end
   end

   // Per-VC framing FSM; out-of-range VCs leave every state untouched
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < MAX_VC; v++) state_q[v] <= VC_IDLE;
      end else if (cfg_load) begin
         for (int v = 0; v < MAX_VC; v++) state_q[v] <= VC_IDLE;
      end else if (accept && vc_in_range) begin
         state_q[flit_if.flit_vc] <= next_state;
      end
   end

   // Saturating statistics and the sticky error flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         flit_count <= '0;
         pkt_count  <= '0;
         err_count  <= '0;
         err_flag   <= 1'b0;
      end else if (cfg_load) begin
         flit_count <= '0;
         pkt_count  <= '0;
         err_count  <= '0;
         err_flag   <= 1'b0;
      end else if (accept) begin
         flit_count <= sat_inc(flit_count);
         if (pkt_done)
            pkt_count <= sat_inc(pkt_count);
         if (|err_cause) begin
            err_count <= sat_inc(err_count);
            err_flag  <= 1'b1;
         end
      end
   end

   // Packet-open status straight from the FSM registers
   always_comb begin
      for (int v = 0; v < MAX_VC; v++) vc_busy[v] = (state_q[v] == VC_OPEN);
   end

`ifdef SINK_LATENCY_EN
   logic [TS_BITS-1:0]          head_ts_q [MAX_VC];
   logic [TS_BITS-1:0]          pkt_lat;
   logic [CNT_BITS+TS_BITS:0]   lat_sum_ext;

   // Latency of the packet completing this cycle (modulo timestamp width)
   always_comb begin
      pkt_lat     = cur_cycle - (flit_if.flit_head ? flit_if.flit_ts : head_ts_q[flit_if.flit_vc]);
      lat_sum_ext = {1'b0, lat_sum} + (CNT_BITS+TS_BITS+1)'(pkt_lat);
   end

   // Head timestamps and latency statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int v = 0; v < MAX_VC; v++) head_ts_q[v] <= '0;
         lat_sum <= '0;
         lat_max <= '0;
      end else if (cfg_load) begin
         for (int v = 0; v < MAX_VC; v++) head_ts_q[v] <= '0;
         lat_sum <= '0;
         lat_max <= '0;
      end else if (accept && vc_in_range) begin
         if (flit_if.flit_head)
            head_ts_q[flit_if.flit_vc] <= flit_if.flit_ts;
         if (pkt_done) begin
            lat_sum <= lat_sum_ext[CNT_BITS+TS_BITS] ? '1 : lat_sum_ext[CNT_BITS+TS_BITS-1:0];
            if (pkt_lat > lat_max)
               lat_max <= pkt_lat;
         end
      end
   end
`endif

   traffic_sink_credit_delay_line #(
      .DEPTH (MAX_CREDIT_DELAY),
      .W     (VC_BITS)
   ) u_credit_delay (
      .clk       (clk),
      .rst       (rst),
      .clr       (cfg_load),
      .tap       (delay_q),
      .in_valid  (accept),
      .in_vc     (flit_if.flit_vc),
      .out_valid (flit_if.cr_valid),
      .out_vc    (flit_if.cr_vc)
   );

endmodule

// File: tb/tb_traffic_sink.sv
// tb_traffic_sink: directed bench for traffic_sink. A packet-level model
// (open-packet flags, counters, a queue of due credits) is compared with
// the DUT every falling edge; literal checks pin the model at key points.
module tb_traffic_sink;
   import traffic_sink_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic                        cfg_load = 1'b0;
   logic [ROUTER_BITS-1:0]      cfg_node_id = '0;
   logic [VC_BITS:0]            cfg_num_vcs = '0;
   logic [3:0]                  cfg_credit_delay = '0;
   logic [CNT_BITS-1:0]         flit_count, pkt_count, err_count;
   logic                        err_flag;
   logic [MAX_VC-1:0]           vc_busy;
`ifdef SINK_LATENCY_EN
   logic [TS_BITS-1:0]          cur_cycle = '0;
   logic [CNT_BITS+TS_BITS-1:0] lat_sum;
   logic [TS_BITS-1:0]          lat_max;
`endif

   traffic_sink_if sif ();

   traffic_sink dut (
      .clk              (clk),
      .rst              (rst),
      .cfg_load         (cfg_load),
      .cfg_node_id      (cfg_node_id),
      .cfg_num_vcs      (cfg_num_vcs),
      .cfg_credit_delay (cfg_credit_delay),
`ifdef SINK_LATENCY_EN
      .cur_cycle        (cur_cycle),
      .lat_sum          (lat_sum),
      .lat_max          (lat_max),
`endif
      .flit_if          (sif),
      .flit_count       (flit_count),
      .pkt_count        (pkt_count),
      .err_count        (err_count),
      .err_flag         (err_flag),
      .vc_busy          (vc_busy)
   );

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int         due;
      logic [1:0] vc;
   } cr_t;

   cr_t     exp_q[$];
   int      edge_n;
   bit      m_open [MAX_VC];
   int      m_flits, m_pkts, m_errs;
   bit      m_eflag;
   int      m_node, m_nvcs, m_delay;
`ifdef SINK_LATENCY_EN
   int      m_ts [MAX_VC];
   longint  m_lsum;
   int      m_lmax;
`endif

   task automatic model_clear_stats();
      exp_q.delete();
      for (int v = 0; v < MAX_VC; v++) m_open[v] = 1'b0;
      m_flits = 0; m_pkts = 0; m_errs = 0; m_eflag = 1'b0;
`ifdef SINK_LATENCY_EN
      for (int v = 0; v < MAX_VC; v++) m_ts[v] = 0;
      m_lsum = 0; m_lmax = 0;
`endif
   endtask

   task automatic model_reset();
      model_clear_stats();
      m_node = 0; m_nvcs = MAX_VC; m_delay = 1;
   endtask

   function automatic int sat(input int v);
      return (v > 65535) ? 65535 : v;
   endfunction

   task automatic model_flit();
      int  v;
      bit  err;
      bit  done;
      int  start;
      v = int'(sif.flit_vc);
      err = 1'b0;
      done = 1'b0;
      start = 0;
      m_flits = sat(m_flits + 1);
      if (sif.flit_head && int'(sif.flit_dst) != m_node) err = 1'b1;
      if (v >= m_nvcs) begin
         err = 1'b1;
      end else if (sif.flit_head) begin
         if (m_open[v]) err = 1'b1;
`ifdef SINK_LATENCY_EN
         m_ts[v] = int'(sif.flit_ts);
`endif
         start = 1;
         m_open[v] = !sif.flit_tail;
         done = sif.flit_tail;
      end else if (!m_open[v]) begin
         err = 1'b1;
      end else if (sif.flit_tail) begin
         m_open[v] = 1'b0;
         done = 1'b1;
      end
      if (err) begin
         m_errs = sat(m_errs + 1);
         m_eflag = 1'b1;
      end
      if (done) begin
         m_pkts = sat(m_pkts + 1);
`ifdef SINK_LATENCY_EN
         begin
            int lat;
            lat = (int'(cur_cycle) - m_ts[v]) & 16'hFFFF;
            m_lsum = m_lsum + lat;
            if (lat > m_lmax) m_lmax = lat;
         end
`endif
      end
      if (start == 0) start = 0;
      exp_q.push_back('{due: edge_n + m_delay - 1, vc: sif.flit_vc});
   endtask

   initial begin
      edge_n = 0;
      model_reset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            model_reset();
         end else begin
            edge_n++;
            if (cfg_load) begin
               model_clear_stats();
               m_node  = int'(cfg_node_id);
               m_nvcs  = int'(cfg_num_vcs);
               m_delay = (cfg_credit_delay == 0) ? 1 :
                         (int'(cfg_credit_delay) > MAX_CREDIT_DELAY) ? MAX_CREDIT_DELAY :
                         int'(cfg_credit_delay);
            end else if (sif.flit_valid) begin
               model_flit();
            end
         end
      end
   end

   // ---------------- compare process (falling edge) ----------------
   initial begin
      forever begin
         @(negedge clk);
         begin
            bit exp_v;
            logic [MAX_VC-1:0] exp_busy;
            while (exp_q.size() > 0 && exp_q[0].due < edge_n) begin
               check("cr_missed", 1'b0, 1'b1);
               void'(exp_q.pop_front());
            end
            exp_v = (exp_q.size() > 0) && (exp_q[0].due == edge_n);
            check("cr_valid", sif.cr_valid, exp_v);
            if (exp_v) begin
               check("cr_vc", sif.cr_vc, exp_q[0].vc);
               void'(exp_q.pop_front());
            end
            for (int v = 0; v < MAX_VC; v++) exp_busy[v] = m_open[v];
            check("flit_count", flit_count, m_flits);
            check("pkt_count", pkt_count, m_pkts);
            check("err_count", err_count, m_errs);
            check("err_flag", err_flag, m_eflag);
            check("vc_busy", vc_busy, exp_busy);
`ifdef SINK_LATENCY_EN
            check("lat_sum", lat_sum, m_lsum);
            check("lat_max", lat_max, m_lmax);
`endif
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic cfg(input int node, input int nvcs, input int d);
      cfg_load         = 1'b1;
      cfg_node_id      = ROUTER_BITS'(node);
      cfg_num_vcs      = (VC_BITS+1)'(nvcs);
      cfg_credit_delay = 4'(d);
      @(posedge clk);
      #1;
      cfg_load = 1'b0;
   endtask

   task automatic send(input int vc, input bit h, input bit t, input int dst);
      sif.flit_valid = 1'b1;
      sif.flit_vc    = VC_BITS'(vc);
      sif.flit_head  = h;
      sif.flit_tail  = t;
      sif.flit_dst   = ROUTER_BITS'(dst);
      @(posedge clk);
      #1;
      sif.flit_valid = 1'b0;
   endtask

   // ---------------- directed stimulus ----------------
   initial begin
      sif.flit_valid = 1'b0;
      sif.flit_vc    = '0;
      sif.flit_head  = 1'b0;
      sif.flit_tail  = 1'b0;
      sif.flit_dst   = '0;
`ifdef SINK_LATENCY_EN
      sif.flit_ts    = '0;
`endif
      repeat (3) @(posedge clk);
      #1;
      check("reset_flit_count", flit_count, 16'd0);
      check("reset_cr_valid", sif.cr_valid, 1'b0);
      check("reset_vc_busy", vc_busy, 4'd0);
      check("reset_err_flag", err_flag, 1'b0);
      rst = 1'b0;
      idle(2);

      // Flit coincident with cfg_load is ignored
      sif.flit_valid = 1'b1; sif.flit_vc = 2'd0; sif.flit_head = 1'b1;
      sif.flit_tail = 1'b1; sif.flit_dst = 4'd3;
      cfg(3, 2, 2);
      sif.flit_valid = 1'b0;
      check("cfg_flit_ignored", flit_count, 16'd0);
      check("cfg_no_credit", sif.cr_valid, 1'b0);

      // Single-flit packet, delay 2
      send(1, 1, 1, 3);
      check("single_flit_count", flit_count, 16'd1);
      check("single_pkt_count", pkt_count, 16'd1);
      check("single_cr_early", sif.cr_valid, 1'b0);
      idle(1);
      check("single_cr_valid", sif.cr_valid, 1'b1);
      check("single_cr_vc", sif.cr_vc, 2'd1);
      idle(1);
      check("single_cr_done", sif.cr_valid, 1'b0);
      check("single_err", err_count, 16'd0);
      idle(3);

      // Interleaved 4-flit vc0 and 2-flit vc1 packets
      cfg(3, 2, 2);
      send(0, 1, 0, 3); check("il_busy_a", vc_busy, 4'b0001);
      send(1, 1, 0, 3); check("il_busy_b", vc_busy, 4'b0011);
      send(0, 0, 0, 0); check("il_busy_c", vc_busy, 4'b0011);
      send(1, 0, 1, 0); check("il_busy_d", vc_busy, 4'b0001);
      send(0, 0, 0, 0); check("il_busy_e", vc_busy, 4'b0001);
      send(0, 0, 1, 0); check("il_busy_f", vc_busy, 4'b0000);
      check("il_pkt_count", pkt_count, 16'd2);
      check("il_flit_count", flit_count, 16'd6);
      idle(4);

      // Body flit on idle vc0
      cfg(3, 2, 2);
      send(0, 0, 0, 0);
      check("body_err_count", err_count, 16'd1);
      check("body_err_flag", err_flag, 1'b1);
      check("body_pkt_count", pkt_count, 16'd0);
      idle(1);
      check("body_credit", sif.cr_valid, 1'b1);
      idle(3);

      // Head on an open VC, then tail; then wrong destination
      cfg(3, 2, 2);
      send(1, 1, 0, 3);
      send(1, 1, 0, 3);
      send(1, 0, 1, 0);
      check("rehead_err_count", err_count, 16'd1);
      check("rehead_pkt_count", pkt_count, 16'd1);
      send(0, 1, 1, 5);
      check("dst_err_count", err_count, 16'd2);
      idle(4);

      // Delay 0 behaves as 1
      cfg(3, 2, 0);
      send(0, 1, 1, 3);
      check("d0_cr_valid", sif.cr_valid, 1'b1);
      check("d0_cr_vc", sif.cr_vc, 2'd0);
      idle(1);
      check("d0_cr_done", sif.cr_valid, 1'b0);

      // Delay 15 clamps to 8
      cfg(3, 2, 15);
      send(1, 1, 1, 3);
      check("d15_t1", sif.cr_valid, 1'b0);
      idle(6);
      check("d15_t7", sif.cr_valid, 1'b0);
      idle(1);
      check("d15_t8", sif.cr_valid, 1'b1);
      check("d15_vc", sif.cr_vc, 2'd1);

      // VC outside the configured range
      send(3, 1, 1, 3);
      check("vcr_err_count", err_count, 16'd1);
      check("vcr_pkt_count", pkt_count, 16'd1);
      check("vcr_busy", vc_busy, 4'd0);
      idle(10);

      // Asynchronous reset with an open packet and credits pending
      cfg(3, 2, 4);
      send(0, 1, 0, 3);
      send(0, 0, 0, 0);
      check("pre_rst_busy", vc_busy, 4'b0001);
      #2;
      rst = 1'b1;
      #1;
      check("arst_busy", vc_busy, 4'd0);
      check("arst_flit_count", flit_count, 16'd0);
      check("arst_cr_valid", sif.cr_valid, 1'b0);
      check("arst_err_flag", err_flag, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      begin
         int seen;
         seen = 0;
         repeat (10) begin
            @(negedge clk);
            if (sif.cr_valid) seen++;
         end
         check("arst_no_credits", seen, 0);
      end
      #1;

`ifdef SINK_LATENCY_EN
      // Latency: head stamped 100, tail at cycle 130
      cfg(3, 2, 1);
      sif.flit_ts = 16'd100;
      cur_cycle   = 16'd100;
      send(0, 1, 0, 3);
      sif.flit_ts = 16'd0;
      cur_cycle   = 16'd130;
      send(0, 0, 1, 0);
      check("lat_max", lat_max, 16'd30);
      check("lat_sum", lat_sum, 32'd30);
      idle(3);
`endif

      idle(2);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
